bcd_serial_add_ctrl: RTL and testbench
======================================

Name: bcd_serial_add_ctrl

Overview:
Sequencer for multi-digit packed-BCD addition that time-shares one single-digit BCD adder. It latches two DIGITS-wide BCD operands on a start request and feeds the digit adder one digit per clock, least-significant digit first, rippling the decimal carry through a register. It sits between a host that issues add requests and the digit-adder datapath, and reports the result with a busy/done handshake plus an invalid-digit flag.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); operand/result width = 4*DIGITS
CW, $clog2(DIGITS+1), digit-counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE or DONE
a  in  4*DIGITS  operand A, packed BCD, digit 0 = a[3:0]
b  in  4*DIGITS  operand B, packed BCD
cin  in  1  decimal carry-in for digit 0
s  out  4*DIGITS  registered BCD sum
cout  out  1  registered decimal carry-out of top digit
busy  out  1  high while digits are being processed
done  out  1  one-cycle pulse when s/cout/err become valid
err  out  1  an operand digit >9 was latched; valid with done

Behaviour:
- Reset (async, rst=1): state=IDLE; s=0, cout=0, busy=0, done=0, err=0; operand regs, carry reg, counter cleared. Reset mid-operation aborts; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1: latch a, b into shift regs, carry<=cin, cnt<=0, err<=(any digit of a or b >9), s<=0, cout<=0; go RUN; busy=1 from the next cycle.
- IDLE/DONE + start=0: stay; DONE->IDLE after one cycle. done=1 only during the single DONE cycle.
- RUN, each cycle: digit adder on low digits of A/B shift regs with carry reg: t=a_d+b_d+c (5-bit); if t>9 then sum=(t+6)[3:0], c_out=1, else sum=t[3:0], c_out=0. Sum shifts in at the top of the s register (s >> 4 with sum in [4*DIGITS-1:4*DIGITS-4]); A/B regs shift right by 4; carry<=c_out; cnt<=cnt+1.
- RUN with cnt==DIGITS-1: after that digit, cout<=c_out, busy<=0, go DONE.
- Latency: start sampled at edge N -> done high in cycle N+DIGITS+1; throughput one add per DIGITS+1 cycles (DONE cycle accepts the next start, i.e. back-to-back adds allowed).
- start while RUN: ignored; no queueing; operands not re-latched.
- s and cout hold their final value from DONE until the next accepted start (cleared then).
- Invalid digits (>9): computation proceeds using the rule above (deterministic output); err asserted, held until the next accepted start or reset.
- a, b, cin need only be stable in the cycle start is sampled.
- Width rule: t max = 15+15+1 = 31, fits 5 bits; correction uses 5-bit add, low nibble taken.

Decomposition:
- Package bcd_pkg: BCD_DIGIT_W=4, BCD_MAX_DIGIT=4'd9, BCD_CORR=4'd6, state enum {IDLE, RUN, DONE}.
- One sub-module: bcd_digit_add (combinational: a_d[3:0], b_d[3:0], c_in -> sum[3:0], c_out) implementing the digit rule above; the controller instantiates exactly one.

Test Plan:
- DIGITS=4: a=16'h1234, b=16'h5678, cin=0, pulse start -> after 5 cycles done=1, s=16'h6912, cout=0, err=0; busy high exactly 4 cycles.
- a=16'h9999, b=16'h0001, cin=0 -> s=16'h0000, cout=1; then a=16'h9999, b=16'h9999, cin=1 issued in the DONE cycle -> s=16'h9999, cout=1, next done 5 cycles later.
- a=16'h0000, b=16'h0000, cin=1 -> s=16'h0001, cout=0; start re-pulsed twice during RUN with a=16'h1111 -> ignored, result unchanged, single done pulse.
- a=16'h00A5, b=16'h0001, cin=0 -> err=1 with done, s=16'h0106, cout=0; next valid add clears err.
- rst asserted 2 cycles into RUN (a=16'h4321, b=16'h1111) -> outputs immediately 0, state IDLE, no done; subsequent add of 16'h0045+16'h0055 -> s=16'h0100, cout=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the serial packed-BCD adder.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder: binary add, then +6 correction
// when the 5-bit total exceeds 9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] t;

  assign t = {1'b0, a_d} + {1'b0, b_d} + {4'b0, c_in};
  assign c_out = t > {1'b0, BCD_MAX_DIGIT};
  // Low nibble of the 5-bit corrected total equals a 4-bit add.
  assign sum = c_out ? (t[3:0] + BCD_CORR) : t[3:0];

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that streams digits LSD-first
// through one shared digit adder, with busy/done/err reporting.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic [4*DIGITS-1:0] s,
  output logic                cout,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int W = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t        state;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [3:0]    d_sum;
  logic          d_cout;
  logic          bad;

  bcd_digit_add u_add (
    .a_d   (a_sr[3:0]),
    .b_d   (b_sr[3:0]),
    .c_in  (carry),
    .sum   (d_sum),
    .c_out (d_cout)
  );

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > BCD_MAX_DIGIT ||
          b[4*i +: 4] > BCD_MAX_DIGIT)
        bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            err   <= bad;
            s     <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // New digit enters at the top; after DIGITS shifts
          // digit 0 has reached s[3:0].
          s     <= (s >> BCD_DIGIT_W) |
                   (W'(d_sum) << (W - BCD_DIGIT_W));
          a_sr  <= a_sr >> BCD_DIGIT_W;
          b_sr  <= b_sr >> BCD_DIGIT_W;
          carry <= d_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout  <= d_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench: decimal reference model, directed and
// randomized adds, latency/busy/hold/reset checks.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b, s;
  logic         cin, cout, busy, done, err;

  int compared = 0;
  int mismatched = 0;

  logic [W+1:0] expq[$];
  logic [W+1:0] hold_exp;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .cout  (cout),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned dec(input logic [W-1:0] x);
    int unsigned v = 0;
    for (int i = DIGITS - 1; i >= 0; i--)
      v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] x);
    for (int i = 0; i < DIGITS; i++)
      if (x[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Returns {err, cout, s}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
    logic [W-1:0] sv = '0;
    int unsigned tot, lim, t, cc;
    if (!has_bad(x) && !has_bad(y)) begin
      lim = 1;
      for (int i = 0; i < DIGITS; i++) lim = lim * 10;
      tot = dec(x) + dec(y) + int'(c);
      cc = (tot >= lim) ? 1 : 0;
      tot = tot % lim;
      for (int i = 0; i < DIGITS; i++) begin
        sv[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
      return {1'b0, cc[0], sv};
    end
    cc = int'(c);
    for (int i = 0; i < DIGITS; i++) begin
      t = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + cc;
      if (t > 9) begin
        sv[4*i +: 4] = 4'((t + 6) % 16);
        cc = 1;
      end else begin
        sv[4*i +: 4] = 4'(t);
        cc = 0;
      end
    end
    return {1'b1, cc[0], sv};
  endfunction

  always @(negedge clk) begin : monitor
    logic [W+1:0] e;
    if (!rst) begin
      if (done) begin
        if (expq.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("result", 32'({err, cout, s}), 32'(e));
          hold_exp = e;
        end
      end else if (!busy) begin
        chk("hold", 32'({err, cout, s}), 32'(hold_exp));
      end
    end
  end

  // Entered and left at a negedge; leaves in the done cycle.
  task automatic run_add(input logic [W-1:0] av,
                         input logic [W-1:0] bv,
                         input logic cv, input logic noise);
    int n = 0;
    int bc = 0;
    a = av;
    b = bv;
    cin = cv;
    start = 1'b1;
    expq.push_back(model(av, bv, cv));
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 3 * DIGITS; k++) begin
      @(negedge clk);
      n++;
      if (noise) begin
        start = (n == 1 || n == 3);
        a = 16'h1111;
      end
      if (busy) bc++;
      if (done) break;
    end
    start = 1'b0;
    chk("latency", 32'(n), 32'(DIGITS + 1));
    chk("busy_cycles", 32'(bc), 32'(DIGITS));
  endtask

  task automatic rnd_op(output logic [W-1:0] x);
    for (int i = 0; i < DIGITS; i++)
      x[4*i +: 4] = ($urandom_range(0, 9) == 0) ?
                    4'($urandom_range(0, 15)) :
                    4'($urandom_range(0, 9));
  endtask

  initial begin : timeout
    #1000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    hold_exp = '0;
    repeat (2) @(negedge clk);
    chk("reset_s", 32'(s), 32'd0);
    chk("reset_flags", 32'({cout, busy, done, err}), 32'd0);
    rst = 1'b0;

    chk("model_6912", 32'(model(16'h1234, 16'h5678, 1'b0)),
        32'h06912);
    chk("model_9999", 32'(model(16'h9999, 16'h9999, 1'b1)),
        32'h19999);
    chk("model_bad", 32'(model(16'h00A5, 16'h0001, 1'b0)),
        32'h20106);

    @(negedge clk);
    run_add(16'h1234, 16'h5678, 1'b0, 1'b0);
    chk("t1", 32'({err, cout, s}), 32'h06912);

    @(negedge clk);
    run_add(16'h9999, 16'h0001, 1'b0, 1'b0);
    chk("t2", 32'({err, cout, s}), 32'h10000);
    run_add(16'h9999, 16'h9999, 1'b1, 1'b0);
    chk("t2_b2b", 32'({err, cout, s}), 32'h19999);

    @(negedge clk);
    run_add(16'h0000, 16'h0000, 1'b1, 1'b1);
    chk("t3_ignore", 32'({err, cout, s}), 32'h00001);
    repeat (4) @(negedge clk);

    run_add(16'h00A5, 16'h0001, 1'b0, 1'b0);
    chk("t4_err", 32'({err, cout, s}), 32'h20106);
    @(negedge clk);
    run_add(16'h0045, 16'h0055, 1'b0, 1'b0);
    chk("t4_clear", 32'({err, cout, s}), 32'h00100);

    @(negedge clk);
    a = 16'h4321;
    b = 16'h1111;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hold_exp = '0;
    #1;
    chk("abort_s", 32'(s), 32'd0);
    chk("abort_flags", 32'({cout, busy, done, err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_add(16'h0045, 16'h0055, 1'b0, 1'b0);
    chk("t5", 32'({err, cout, s}), 32'h00100);

    for (int i = 0; i < 60; i++) begin
      rnd_op(ra);
      rnd_op(rb);
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      run_add(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
